clktick_sync: RTL and testbench

Clock-domain receiver for the ripple divider's slow clock outputs. Each asynchronous slow clock is resynchronised into the `clk` domain and turned into a one-cycle `tick` enable. The block measures each channel's period in `clk` cycles against its expected divide ratio and reports lock and error status. It sits between the clock divider and the synthesiser datapath, so downstream logic can run on `clk` with enables instead of ripple clocks.

---
 rtl/clktick_sync_if.sv | 34 +++
 rtl/clktick_sync.sv | 181 ++++++++++++++++++
 tb/tb_clktick_sync.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clktick_sync_if.sv
// clktick_sync_if: signal bundle between the slow-clock sources / consumers
// and the clktick_sync receiver.
//   clk_in  [N_CH] : slow divided clocks, asynchronous to the receiver clock
//   err_clr        : one-cycle pulse clearing every sticky error bit
//   tick    [N_CH] : one-cycle strobe per slow-clock rising edge
//   locked  [N_CH] : channel period verified
//   err     [N_CH] : sticky period / stall error
// The master modport is the side that drives clk_in/err_clr and observes
// status; the slave modport is the receiver itself.
interface clktick_sync_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] clk_in;
  logic            err_clr;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] locked;
  logic [N_CH-1:0] err;

  modport master (
    output clk_in,
    output err_clr,
    input  tick,
    input  locked,
    input  err
  );

  modport slave (
    input  clk_in,
    input  err_clr,
    output tick,
    output locked,
    output err
  );
endinterface

// File: rtl/clktick_sync.sv
// clktick_sync: receives the ripple divider's slow clocks, resynchronises
// each one into the clk domain, turns every rising edge into a one-cycle
// tick enable and checks the measured period against the expected divide.
//   clk    : master clock (also the divider input)
//   arstn  : asynchronous active-low reset
//   bus    : clktick_sync_if slave (clk_in, err_clr in; tick, locked, err out)
// Every channel is an independent copy of the same synchroniser, arm gate,
// period counter and UNARMED/FIRST/TRACK state machine.
module clktick_sync #(
  parameter int                N_CH        = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                CNT_W       = 18,
  parameter logic [5*N_CH-1:0] DIV_LOG2    = {5'd5, 5'd16, 5'd8, 5'd9},
  parameter int                TOL         = 1,
  parameter int                LOCK_CNT    = 2
) (
  input logic           clk,
  input logic           arstn,
  clktick_sync_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_FIRST   = 2'd1,
    ST_TRACK   = 2'd2
  } ch_state_e;

  localparam int                PASS_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(LOCK_CNT);

  logic [N_CH-1:0] tick_s;
  logic [N_CH-1:0] locked_s;
  logic [N_CH-1:0] err_s;

  assign bus.tick   = tick_s;
  assign bus.locked = locked_s;
  assign bus.err    = err_s;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // Window limits are computed one bit wider than the counter so that the
    // measured period (counter + 1) and the stall limit never wrap.
    localparam int             DIV_C   = int'(DIV_LOG2[5*gi +: 5]);
    localparam logic [CNT_W:0] ONE_C   = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] TOL_C   = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0] NOM_C   = ONE_C << DIV_C;
    localparam logic [CNT_W:0] LO_C    = (NOM_C > TOL_C) ? (NOM_C - TOL_C) : {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0] HI_C    = NOM_C + TOL_C;
    localparam logic [CNT_W:0] STALL_C = (NOM_C << 1) + TOL_C;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] vld_r;
    logic                   prev_r;
    ch_state_e              state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s, cnt_inc_s;
    logic [PASS_W-1:0]      pass_r, pass_s;
    logic                   stalled_r, stalled_s;
    logic                   tick_r, locked_r, err_r;
    logic                   locked_nx_s, err_nx_s;
    logic                   sync_val_s, armable_s, edge_s, stall_s, in_win_s;
    logic [CNT_W:0]         period_s;

    assign sync_val_s = sync_r[SYNC_STAGES-1];
    // vld_r tracks which synchroniser stages hold real samples, so the reset
    // value of the flops is never mistaken for an observed low level.
    assign armable_s  = vld_r[SYNC_STAGES-1] & ~sync_val_s;
    assign edge_s     = sync_val_s & ~prev_r & (state_r != ST_UNARMED);
    // The counter is 0 in the tick cycle, so the period is one more.
    assign period_s   = {1'b0, cnt_r} + ONE_C;
    assign in_win_s   = (period_s >= LO_C) && (period_s <= HI_C);
    // Only one stall is reported per silence: stalled_r freezes the counter.
    assign stall_s    = (state_r != ST_UNARMED) && !edge_s && !stalled_r &&
                        ({1'b0, cnt_r} == STALL_C);
    assign cnt_inc_s  = (stalled_r || (&cnt_r)) ? cnt_r : (cnt_r + CNT_W'(1));

    // Synchroniser chain, its sample-valid shadow and the edge history flop.
    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        sync_r <= {SYNC_STAGES{1'b0}};
        vld_r  <= {SYNC_STAGES{1'b0}};
        prev_r <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], bus.clk_in[gi]};
        vld_r  <= {vld_r[SYNC_STAGES-2:0], 1'b1};
        prev_r <= sync_val_s;
      end
    end

    // Channel state machine: arm gate, period compare, stall detection.
    always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      pass_s    = pass_r;
      stalled_s = stalled_r;
      if (bus.err_clr) begin
        err_nx_s = 1'b0;
      end else begin
        err_nx_s = err_r;
      end
      case (state_r)
        ST_UNARMED: begin
          cnt_s = {CNT_W{1'b0}};
          if (armable_s) begin
            state_s = ST_FIRST;
          end else begin
            state_s = ST_UNARMED;
          end
        end
        ST_FIRST: begin
          if (edge_s) begin
            state_s   = ST_TRACK;
            cnt_s     = {CNT_W{1'b0}};
            stalled_s = 1'b0;
          end else if (stall_s) begin
            err_nx_s  = 1'b1;
            pass_s    = {PASS_W{1'b0}};
            stalled_s = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_TRACK: begin
          if (edge_s) begin
            cnt_s     = {CNT_W{1'b0}};
            stalled_s = 1'b0;
            if (in_win_s) begin
              if (pass_r != PASS_MAX) begin
                pass_s = pass_r + PASS_W'(1);
              end else begin
                pass_s = pass_r;
              end
            end else begin
              // A failing tick still restarts the counter: it is the new reference.
              err_nx_s = 1'b1;
              pass_s   = {PASS_W{1'b0}};
            end
          end else if (stall_s) begin
            state_s   = ST_FIRST;
            err_nx_s  = 1'b1;
            pass_s    = {PASS_W{1'b0}};
            stalled_s = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        default: begin
          state_s   = ST_UNARMED;
          cnt_s     = {CNT_W{1'b0}};
          pass_s    = {PASS_W{1'b0}};
          stalled_s = 1'b0;
        end
      endcase
      locked_nx_s = (pass_s == PASS_MAX);
    end

    // Channel state, counters and registered outputs.
    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        state_r   <= ST_UNARMED;
        cnt_r     <= {CNT_W{1'b0}};
        pass_r    <= {PASS_W{1'b0}};
        stalled_r <= 1'b0;
        tick_r    <= 1'b0;
        locked_r  <= 1'b0;
        err_r     <= 1'b0;
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        pass_r    <= pass_s;
        stalled_r <= stalled_s;
        tick_r    <= edge_s;
        locked_r  <= locked_nx_s;
        err_r     <= err_nx_s;
      end
    end

    assign tick_s[gi]   = tick_r;
    assign locked_s[gi] = locked_r;
    assign err_s[gi]    = err_r;
  end

endmodule

// File: tb/tb_clktick_sync.sv
// tb_clktick_sync: self-checking bench for clktick_sync with default
// parameters. Rising edges driven on a channel push the expected tick cycle
// into a scoreboard; a negedge monitor records the ticks the receiver emits,
// and each scenario task pops and compares both queues.
module tb_clktick_sync;
  logic clk;
  logic arstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] man_clk = 4'b0000;
  logic [3:0] gen_clk = 4'b0000;
  logic [3:0] gen_en  = 4'b0000;
  int         gen_cnt [4] = '{0, 0, 0, 0};
  int         gen_half [4] = '{256, 128, 32768, 16};

  typedef struct {
    int ch;
    int cyc;
  } tick_ev_t;

  tick_ev_t exp_q[$];
  tick_ev_t obs_q[$];
  tick_ev_t mon_ev;

  clktick_sync_if #(.N_CH(4)) bus ();

  assign bus.clk_in = (gen_clk & gen_en) | (man_clk & ~gen_en);

  clktick_sync #(
    .N_CH(4), .SYNC_STAGES(2), .CNT_W(18),
    .DIV_LOG2({5'd5, 5'd16, 5'd8, 5'd9}), .TOL(1), .LOCK_CNT(2)
  ) dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitor: log every observed tick with its cycle number.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (bus.tick[c] === 1'b1) begin
        mon_ev.ch  = c;
        mon_ev.cyc = cyc;
        obs_q.push_back(mon_ev);
      end
    end
  end

  // Free-running square-wave sources at each channel's nominal period.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (gen_en[g] !== 1'b1) begin
        gen_cnt[g] = 0;
        gen_clk[g] = 1'b0;
      end else if (gen_cnt[g] == gen_half[g] - 1) begin
        gen_cnt[g] = 0;
        gen_clk[g] = ~gen_clk[g];
      end else begin
        gen_cnt[g] = gen_cnt[g] + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [3:0] init);
    arstn       = 1'b0;
    man_clk     = init;
    gen_en      = 4'b0000;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
  endtask

  // One high/low period on a manually driven channel. Samples locked/err in
  // the cycle the tick for this rising edge is due.
  task automatic drive_period(input int ch, input int hi, input int lo, input bit exp_tick,
                              output logic lk, output logic er, output int rc);
    tick_ev_t ev;
    rc          = cyc;
    lk          = 1'bx;
    er          = 1'bx;
    man_clk[ch] = 1'b1;
    if (exp_tick) begin
      ev.ch  = ch;
      ev.cyc = rc + 3;
      exp_q.push_back(ev);
    end
    repeat (hi) begin
      @(negedge clk);
      if (cyc == rc + 3) begin
        lk = bus.locked[ch];
        er = bus.err[ch];
      end
    end
    man_clk[ch] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    arstn       = 1'b0;
    man_clk     = 4'b0000;
    gen_en      = 4'b0000;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.tick !== 4'b0000) begin errors++; $display("FAIL reset_tick: got %b want 0000", bus.tick); end
    checks++; if (bus.locked !== 4'b0000) begin errors++; $display("FAIL reset_locked: got %b want 0000", bus.locked); end
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", bus.err); end
    arstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if ({bus.tick, bus.locked, bus.err} !== 12'h000) begin
      errors++; $display("FAIL reset_idle: got %h want 000", {bus.tick, bus.locked, bus.err});
    end
  endtask

  task automatic test_arm_gate();
    logic lk, er;
    int   r;
    tick_ev_t e, o;
    do_reset(4'b0001);
    repeat (10) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL arm_gate_high_at_reset: got %0d ticks want 0", obs_q.size()); end
    man_clk[0] = 1'b0;
    repeat (6) @(negedge clk);
    drive_period(0, 8, 8, 1'b1, lk, er, r);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL arm_tick_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.cyc !== e.cyc) begin errors++; $display("FAIL arm_tick_time: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_nominal_lock();
    logic lk [4];
    logic er [4];
    int   r;
    tick_ev_t e, o;
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) drive_period(3, 16, 16, 1'b1, lk[i], er[i], r);
    checks++; if (lk[1] !== 1'b0) begin errors++; $display("FAIL nominal_lock_tick2: got %b want 0", lk[1]); end
    checks++; if (lk[2] !== 1'b1) begin errors++; $display("FAIL nominal_lock_tick3: got %b want 1", lk[2]); end
    checks++; if (lk[3] !== 1'b1) begin errors++; $display("FAIL nominal_lock_tick4: got %b want 1", lk[3]); end
    checks++; if (bus.err[3] !== 1'b0) begin errors++; $display("FAIL nominal_err: got %b want 0", bus.err[3]); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL nominal_tick_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.cyc !== e.cyc) begin errors++; $display("FAIL nominal_tick_time: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_tolerance();
    // Periods driven: 32,32,33,34,32,32,(hold). Tick k measures period k-1.
    int   hi_t [7] = '{16, 16, 16, 16, 16, 16, 16};
    int   lo_t [7] = '{16, 16, 17, 18, 16, 16, 16};
    logic lk [7];
    logic er [7];
    int   r;
    tick_ev_t e, o;
    do_reset(4'b0000);
    for (int i = 0; i < 7; i++) drive_period(3, hi_t[i], lo_t[i], 1'b1, lk[i], er[i], r);
    checks++; if (lk[2] !== 1'b1) begin errors++; $display("FAIL tol_pre_lock: got %b want 1", lk[2]); end
    checks++; if ({lk[3], er[3]} !== 2'b10) begin errors++; $display("FAIL tol_33_pass: got lk,err=%b%b want 10", lk[3], er[3]); end
    checks++; if ({lk[4], er[4]} !== 2'b01) begin errors++; $display("FAIL tol_34_fail: got lk,err=%b%b want 01", lk[4], er[4]); end
    checks++; if (lk[5] !== 1'b0) begin errors++; $display("FAIL tol_relock_pass1: got %b want 0", lk[5]); end
    checks++; if ({lk[6], er[6]} !== 2'b11) begin errors++; $display("FAIL tol_relock_pass2: got lk,err=%b%b want 11", lk[6], er[6]); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL tol_tick_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.cyc !== e.cyc) begin errors++; $display("FAIL tol_tick_time: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    logic lk [7];
    logic er [7];
    int   r, t;
    tick_ev_t e, o;
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) drive_period(3, 16, 16, 1'b1, lk[i], er[i], r);
    checks++; if (lk[3] !== 1'b1) begin errors++; $display("FAIL stall_pre_lock: got %b want 1", lk[3]); end
    // Counter is 0 in the tick cycle t; it reads 65 in cycle t+65, err follows.
    t = r + 3;
    while (cyc < t + 65) @(negedge clk);
    checks++; if ({bus.locked[3], bus.err[3]} !== 2'b10) begin errors++; $display("FAIL stall_early: got lk,err=%b%b want 10", bus.locked[3], bus.err[3]); end
    @(negedge clk);
    checks++; if ({bus.locked[3], bus.err[3]} !== 2'b01) begin errors++; $display("FAIL stall_detect: got lk,err=%b%b want 01", bus.locked[3], bus.err[3]); end
    repeat (3) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++; if (bus.err[3] !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b want 0", bus.err[3]); end
    repeat (200) @(negedge clk);
    checks++; if (bus.err[3] !== 1'b0) begin errors++; $display("FAIL stall_single: got %b want 0", bus.err[3]); end
    for (int i = 4; i < 7; i++) drive_period(3, 16, 16, 1'b1, lk[i], er[i], r);
    checks++; if ({lk[4], er[4]} !== 2'b00) begin errors++; $display("FAIL stall_restart_first: got lk,err=%b%b want 00", lk[4], er[4]); end
    checks++; if (lk[5] !== 1'b0) begin errors++; $display("FAIL stall_restart_pass1: got %b want 0", lk[5]); end
    checks++; if ({lk[6], er[6]} !== 2'b10) begin errors++; $display("FAIL stall_relock: got lk,err=%b%b want 10", lk[6], er[6]); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_tick_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.cyc !== e.cyc) begin errors++; $display("FAIL stall_tick_time: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear_collision();
    logic lk, er;
    int   r;
    tick_ev_t ev, e, o;
    do_reset(4'b0000);
    // First ch1 tick (no compare), then a 200-cycle period that must fail.
    drive_period(1, 128, 72, 1'b1, lk, er, r);
    r = cyc;
    man_clk[1] = 1'b1;
    ev.ch = 1; ev.cyc = r + 3; exp_q.push_back(ev);
    repeat (2) @(negedge clk);
    // ch3 has been idle since reset and has stalled by now.
    checks++; if (bus.err[3] !== 1'b1) begin errors++; $display("FAIL clr_pre_err3: got %b want 1", bus.err[3]); end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++; if (bus.err[1] !== 1'b1) begin errors++; $display("FAIL clr_collision_err1: got %b want 1", bus.err[1]); end
    checks++; if (bus.err[3] !== 1'b0) begin errors++; $display("FAIL clr_collision_err3: got %b want 0", bus.err[3]); end
    repeat (125) @(negedge clk);
    man_clk[1] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.err !== 4'b0010) begin errors++; $display("FAIL clr_pre_alone: got %b want 0010", bus.err); end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL clr_alone: got %b want 0000", bus.err); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clr_tick_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.ch !== e.ch || o.cyc !== e.cyc) begin errors++; $display("FAIL clr_tick_time: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_midrun_reset();
    do_reset(4'b0000);
    gen_en = 4'b1111;
    repeat (2000) @(negedge clk);
    // ch2 (period 65536) has not ticked yet; the other three are locked.
    checks++; if (bus.locked !== 4'b1011) begin errors++; $display("FAIL midrun_pre_locked: got %b want 1011", bus.locked); end
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL midrun_pre_err: got %b want 0000", bus.err); end
    #2 arstn = 1'b0;
    #1;
    checks++; if ({bus.tick, bus.locked, bus.err} !== 12'h000) begin
      errors++; $display("FAIL midrun_async_reset: got %h want 000", {bus.tick, bus.locked, bus.err});
    end
    arstn = 1'b1;
    @(negedge clk);
    repeat (150) @(negedge clk);
    checks++; if (bus.locked !== 4'b1000) begin errors++; $display("FAIL midrun_relock_ch3: got %b want 1000", bus.locked); end
    repeat (2100) @(negedge clk);
    checks++; if (bus.locked !== 4'b1011) begin errors++; $display("FAIL midrun_relock_all: got %b want 1011", bus.locked); end
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL midrun_err: got %b want 0000", bus.err); end
    gen_en = 4'b0000;
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    arstn       = 1'b0;
    bus.err_clr = 1'b0;
    test_reset();
    test_arm_gate();
    test_nominal_lock();
    test_tolerance();
    test_stall();
    test_clear_collision();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
